// File: rtl/bitbang_port.sv
// Bit-banged configuration port: synchronised serial data/control shift registers,
// keyed command decode into per-channel data registers, and a serial readback path.
module bitbang_port #(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           CTRL_WIDTH  = 16,
  parameter logic [CTRL_WIDTH-5:0] KEY         = 12'hFAB,
  parameter int unsigned           NUM_CH      = 2,
  parameter int unsigned           SYNC_STAGES = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         s_clk,
  input  logic                         s_data,
  output logic                         s_dout,
  output logic [NUM_CH*DATA_WIDTH-1:0] data,
  output logic [NUM_CH-1:0]            strobe,
  output logic                         active,
  output logic                         cmd_err
);

  localparam logic [3:0] OP_OFF  = 4'h0;
  localparam logic [3:0] OP_READ = 4'hE;
  localparam logic [3:0] OP_CLR  = 4'hF;

  logic [SYNC_STAGES-1:0]       r_sclk_sync;
  logic [SYNC_STAGES-1:0]       r_sdat_sync;
  logic                         r_sclk_hist;
  logic [DATA_WIDTH-1:0]        r_serial_data;
  logic [CTRL_WIDTH-1:0]        r_serial_ctrl;
  logic                         r_cmd_pending;
  logic [DATA_WIDTH-1:0]        r_readback;
  logic [NUM_CH*DATA_WIDTH-1:0] r_data;
  logic [NUM_CH-1:0]            r_strobe;
  logic                         r_active;
  logic                         r_cmd_err;

  logic                  w_sclk;
  logic                  w_sdat;
  logic                  w_rise;
  logic                  w_fall;
  logic [3:0]            w_op;
  logic                  w_cmd_fire;
  logic                  w_ch_hit;
  logic [NUM_CH-1:0]     w_ld_mask;
  logic                  w_rb_hit;
  logic [DATA_WIDTH-1:0] w_rb_sel;

  assign w_sclk     = r_sclk_sync[SYNC_STAGES-1];
  assign w_sdat     = r_sdat_sync[SYNC_STAGES-1];
  assign w_rise     = w_sclk & ~r_sclk_hist;
  assign w_fall     = ~w_sclk & r_sclk_hist;
  assign w_op       = r_serial_ctrl[3:0];
  // Only the cycle right after a control shift may act on the control word.
  assign w_cmd_fire = r_cmd_pending && (r_serial_ctrl[CTRL_WIDTH-1:4] == KEY);

  // Channel-load opcode decode and readback channel select.
  always_comb begin
    w_ch_hit  = 1'b0;
    w_ld_mask = '0;
    w_rb_hit  = 1'b0;
    w_rb_sel  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (w_op == 4'(k + 1)) begin
        w_ld_mask[k] = 1'b1;
        w_ch_hit     = 1'b1;
      end
      if (r_serial_data[3:0] == 4'(k)) begin
        w_rb_hit = 1'b1;
        w_rb_sel = r_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sclk_sync   <= '0;
      r_sdat_sync   <= '0;
      r_sclk_hist   <= 1'b0;
      r_serial_data <= '0;
      r_serial_ctrl <= '0;
      r_cmd_pending <= 1'b0;
      r_readback    <= '0;
      r_data        <= '0;
      r_strobe      <= '0;
      r_active      <= 1'b0;
      r_cmd_err     <= 1'b0;
    end else begin
      r_sclk_sync   <= {r_sclk_sync[SYNC_STAGES-2:0], s_clk};
      r_sdat_sync   <= {r_sdat_sync[SYNC_STAGES-2:0], s_data};
      r_sclk_hist   <= w_sclk;
      r_cmd_pending <= w_fall;
      r_strobe      <= '0;
      r_cmd_err     <= 1'b0;

      if (w_rise) begin
        r_serial_data <= {r_serial_data[DATA_WIDTH-2:0], w_sdat};
        r_readback    <= {r_readback[DATA_WIDTH-2:0], 1'b0};
      end
      if (w_fall) begin
        r_serial_ctrl <= {r_serial_ctrl[CTRL_WIDTH-2:0], w_sdat};
      end

      // A readback load below overrides the shift above.
      if (w_cmd_fire) begin
        if (w_op == OP_OFF) begin
          r_active <= 1'b0;
        end else if (w_ch_hit) begin
          for (int k = 0; k < NUM_CH; k++) begin
            if (w_ld_mask[k]) r_data[k*DATA_WIDTH +: DATA_WIDTH] <= r_serial_data;
          end
          r_active <= 1'b1;
          r_strobe <= w_ld_mask;
        end else if (w_op == OP_READ) begin
          r_readback <= w_rb_hit ? w_rb_sel : '0;
          r_cmd_err  <= ~w_rb_hit;
        end else if (w_op == OP_CLR) begin
          r_data <= '0;
        end else begin
          r_cmd_err <= 1'b1;
        end
      end
    end
  end

  assign s_dout  = r_readback[DATA_WIDTH-1];
  assign data    = r_data;
  assign strobe  = r_strobe;
  assign active  = r_active;
  assign cmd_err = r_cmd_err;

endmodule

// File: tb/tb_bitbang_port.sv
// Bench for bitbang_port: event-level reference model checked every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_bitbang_port;

  localparam int unsigned DW   = 32;
  localparam int unsigned CW   = 16;
  localparam int unsigned NCH  = 2;
  localparam int unsigned SYNC = 3;
  localparam logic [11:0] KEY  = 12'hFAB;

  logic              clk;
  logic              reset;
  logic              s_clk;
  logic              s_data;
  logic              s_dout;
  logic [NCH*DW-1:0] data;
  logic [NCH-1:0]    strobe;
  logic              active;
  logic              cmd_err;

  bitbang_port #(
    .DATA_WIDTH(DW), .CTRL_WIDTH(CW), .KEY(KEY), .NUM_CH(NCH), .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk), .reset(reset), .s_clk(s_clk), .s_data(s_data), .s_dout(s_dout),
    .data(data), .strobe(strobe), .active(active), .cmd_err(cmd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int   due;
    logic rise;
    logic b;
  } ev_t;

  ev_t  ev_q[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   stb_cnt0 = 0;
  int   stb_cnt1 = 0;
  int   err_cnt = 0;
  int   first_stb0 = -1;
  int   last_toggle = 0;

  // Reference model state
  logic [DW-1:0] m_sd, m_rb;
  logic [CW-1:0] m_sc;
  logic [DW-1:0] m_ch [NCH];
  logic          m_act, m_err, m_eval;
  logic [NCH-1:0] m_stb;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Edges reach the core SYNC cycles after the first sampling clk edge; commands act one edge later.
  task automatic model_step();
    int   op;
    int   idx;
    logic loaded;
    ev_t  e;
    if (reset) begin
      m_sd = '0; m_sc = '0; m_rb = '0; m_act = 1'b0; m_err = 1'b0; m_eval = 1'b0; m_stb = '0;
      for (int k = 0; k < NCH; k++) m_ch[k] = '0;
      ev_q.delete();
      return;
    end
    m_stb  = '0;
    m_err  = 1'b0;
    loaded = 1'b0;
    if (m_eval && m_sc[15:4] == KEY) begin
      op = int'(m_sc[3:0]);
      if (op == 0) m_act = 1'b0;
      else if (op >= 1 && op <= NCH) begin
        m_ch[op-1]  = m_sd;
        m_act       = 1'b1;
        m_stb[op-1] = 1'b1;
      end else if (op == 14) begin
        idx    = int'(m_sd[3:0]);
        loaded = 1'b1;
        if (idx < NCH) m_rb = m_ch[idx];
        else begin
          m_rb  = '0;
          m_err = 1'b1;
        end
      end else if (op == 15) begin
        for (int k = 0; k < NCH; k++) m_ch[k] = '0;
      end else m_err = 1'b1;
    end
    m_eval = 1'b0;
    while (ev_q.size() > 0 && ev_q[0].due <= cyc) begin
      e = ev_q.pop_front();
      if (e.rise) begin
        m_sd = {m_sd[DW-2:0], e.b};
        if (!loaded) m_rb = {m_rb[DW-2:0], 1'b0};
      end else begin
        m_sc   = {m_sc[CW-2:0], e.b};
        m_eval = 1'b1;
      end
    end
  endtask

  // Per-cycle compare against the model, sampled just after each rising clk edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      model_step();
      chk("data",    64'(data),    64'({m_ch[1], m_ch[0]}));
      chk("strobe",  64'(strobe),  64'(m_stb));
      chk("active",  64'(active),  64'(m_act));
      chk("cmd_err", 64'(cmd_err), 64'(m_err));
      chk("s_dout",  64'(s_dout),  64'(m_rb[DW-1]));
      if (strobe[0]) stb_cnt0++;
      if (strobe[1]) stb_cnt1++;
      if (cmd_err) err_cnt++;
      if (strobe[0] && first_stb0 < 0) first_stb0 = cyc;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic d);
    ev_t e;
    s_data = d;
    wait_clk(3);
    s_clk       = v;
    e.due       = cyc + 1 + int'(SYNC);
    e.rise      = v;
    e.b         = d;
    ev_q.push_back(e);
    last_toggle = cyc;
    wait_clk(4);
  endtask

  // One serial bit per s_clk period: data on rise, control on fall during the last 16 periods.
  task automatic send_bits(input logic [31:0] dw, input logic [15:0] cw, input int nbits);
    logic [31:0] cx;
    cx = {cw, 16'h0000};
    for (int i = 0; i < nbits; i++) begin
      drive(1'b1, dw[31-i]);
      drive(1'b0, (i >= 16) ? cx[31-(i-16)] : 1'b0);
    end
    wait_clk(6);
  endtask

  task automatic send_frame(input logic [31:0] dw, input logic [15:0] cw);
    send_bits(dw, cw, 32);
  endtask

  task automatic clr_counts();
    stb_cnt0 = 0; stb_cnt1 = 0; err_cnt = 0; first_stb0 = -1;
  endtask

  initial begin
    logic [31:0] pat;
    int          t_fall;
    reset  = 1'b1;
    s_clk  = 1'b0;
    s_data = 1'b0;
    wait_clk(3);
    reset = 1'b0;
    wait_clk(2);
    chk("reset_data",   64'(data),   64'h0);
    chk("reset_active", 64'(active), 64'h0);
    chk("reset_dout",   64'(s_dout), 64'h0);

    // Load channel 0; strobe lands SYNC+2 cycles after the final fall is driven
    clr_counts();
    send_frame(32'hDEADBEEF, 16'hFAB1);
    t_fall = last_toggle;
    chk("ch0_load",    64'(data[31:0]), 64'hDEADBEEF);
    chk("ch0_active",  64'(active),     64'h1);
    chk("ch0_strobes", 64'(stb_cnt0),   64'd1);
    chk("ch0_latency", 64'(first_stb0), 64'(t_fall + 5));

    clr_counts();
    send_frame(32'h12345678, 16'hFAB2);
    chk("ch1_load",    64'(data[63:32]), 64'h12345678);
    chk("ch1_strobes", 64'(stb_cnt1),    64'd1);
    send_frame(32'h00000000, 16'hFAB0);
    chk("off_active",  64'(active),      64'h0);
    chk("off_ch0",     64'(data[31:0]),  64'hDEADBEEF);

    // Invalid opcodes and a wrong key
    clr_counts();
    send_frame(32'hCAFEF00D, 16'hFAB7);
    chk("op7_err",   64'(err_cnt),  64'd1);
    chk("op7_data",  64'(data),     64'h12345678_DEADBEEF);
    chk("op7_stb",   64'(stb_cnt0 + stb_cnt1), 64'd0);
    chk("op7_act",   64'(active),   64'h0);
    clr_counts();
    send_frame(32'hCAFEF00D, 16'h1231);
    chk("nokey_err", 64'(err_cnt + stb_cnt0 + stb_cnt1), 64'd0);
    chk("nokey_data", 64'(data),    64'h12345678_DEADBEEF);
    clr_counts();
    send_frame(32'hCAFEF00D, 16'hFAB3);
    chk("op3_err",   64'(err_cnt),  64'd1);

    // Repeated loads of the same channel each strobe
    clr_counts();
    send_frame(32'h0BADF00D, 16'hFAB1);
    send_frame(32'h0BADF00D, 16'hFAB1);
    chk("b2b_strobes", 64'(stb_cnt0),  64'd2);
    chk("b2b_data",    64'(data[31:0]), 64'h0BADF00D);

    // Readback of channel 0
    send_frame(32'hA5A5A5A5, 16'hFAB1);
    send_frame(32'h00000000, 16'hFABE);
    pat = 32'hA5A5A5A5;
    for (int i = 0; i < 32; i++) begin
      chk("readback_bit", 64'(s_dout), 64'(pat[31-i]));
      drive(1'b1, 1'b0);
      drive(1'b0, 1'b0);
    end
    chk("readback_drained", 64'(s_dout), 64'h0);

    // Readback index out of range
    clr_counts();
    send_frame(32'h00000005, 16'hFABE);
    chk("rb_oor_err",  64'(err_cnt), 64'd1);
    chk("rb_oor_dout", 64'(s_dout),  64'h0);

    // Clear all channels
    clr_counts();
    send_frame(32'h00000000, 16'hFABF);
    chk("clr_data",   64'(data),     64'h0);
    chk("clr_stb",    64'(stb_cnt0 + stb_cnt1), 64'd0);
    chk("clr_active", 64'(active),   64'h1);

    // Reset mid-word discards the partial command
    clr_counts();
    send_bits(32'h11111111, 16'hFAB1, 26);
    chk("partial_stb", 64'(stb_cnt0), 64'd0);
    reset = 1'b1;
    wait_clk(2);
    reset = 1'b0;
    wait_clk(2);
    chk("rst_data",   64'(data),   64'h0);
    chk("rst_active", 64'(active), 64'h0);
    send_frame(32'h22222222, 16'hFAB1);
    chk("post_rst_stb",  64'(stb_cnt0),    64'd1);
    chk("post_rst_data", 64'(data[31:0]),  64'h22222222);

    wait_clk(4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
